uart_tx_arbiter: RTL

Shares one UART transmitter (byte-wide tx_data/tx_wr/tx_busy interface) between NUM_REQ byte-stream requesters. The arbiter runs round-robin, can optionally hold the grant for a whole packet, and paces writes strictly on the transmitter's busy handshake. It sits between client blocks (debug console, status reporter, etc.) and the uart instance's TX side.

---
 rtl/uart_ctrl_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the UART TX arbiter slice.
// Contents:
//   arb_state_e - arbiter FSM states
//   id_width()  - ceil(log2(n)), minimum 1; sizes index and counter fields
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    StArb,
    StSend,
    StWaitBusy,
    StWaitDone
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte-stream bus shared by NUM_REQ clients.
// Signals:
//   req_valid [NUM_REQ]    - byte available per requester
//   req_data  [8*NUM_REQ]  - requester i uses bits [8i+7:8i]
//   req_last  [NUM_REQ]    - byte closes its packet
//   req_ready [NUM_REQ]    - one-hot accept; byte consumed when valid & ready
// Modports: master = requesters, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req       - request vector
//   ptr       - last served index; search starts at ptr+1 and wraps
//   winner    - index of first set request found
//   any_valid - at least one request is set
module uart_rr_pick
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW   = id_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdW-1:0]    ptr,
  output logic [IdW-1:0]    winner,
  output logic              any_valid
);

  logic [IdW-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = IdW'((32'(ptr) + i) % NumReq);
      if (!any_valid && req[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin arbitration, optional packet lock, writes paced on uart_tx_busy.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   req_bus        - requester bus (slave modport)
//   uart_tx_data   - byte to UART (registered)
//   uart_tx_wr     - single-cycle write strobe (registered)
//   uart_tx_busy   - UART transmitter busy
//   grant_valid    - a requester owns the UART
//   grant_id       - owning requester
//   timeout_err    - sticky: busy never rose after a write
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_PACKETS = 1,
  parameter int unsigned BUSY_TIMEOUT = 64,
  localparam int unsigned IdW         = id_width(NUM_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.slave  req_bus,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_wr,
  input  logic              uart_tx_busy,
  output logic              grant_valid,
  output logic [IdW-1:0]    grant_id,
  output logic              timeout_err
);

  localparam int unsigned CntW = id_width(BUSY_TIMEOUT + 1);

  arb_state_e     state_q;
  logic [IdW-1:0] ptr_q;
  logic           last_q;
  logic [CntW-1:0] cnt_q;

  logic [IdW-1:0] winner;
  logic           any_valid;
  logic           send_ok;

  uart_rr_pick #(
    .NumReq(NUM_REQ)
  ) u_pick (
    .req       (req_bus.req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Byte is accepted in the same cycle it is written into the output register.
  assign send_ok = (state_q == StSend) && req_bus.req_valid[grant_id] && !uart_tx_busy;
  assign req_bus.req_ready = send_ok ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StArb;
      ptr_q        <= IdW'(NUM_REQ - 1);
      last_q       <= 1'b0;
      cnt_q        <= '0;
      uart_tx_data <= 8'h00;
      uart_tx_wr   <= 1'b0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      uart_tx_wr <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (any_valid) begin
            grant_id    <= winner;
            grant_valid <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (!req_bus.req_valid[grant_id]) begin
            // Requester withdrew mid-packet: give the UART to someone else.
            ptr_q       <= grant_id;
            grant_valid <= 1'b0;
            state_q     <= StArb;
          end else if (!uart_tx_busy) begin
            uart_tx_data <= req_bus.req_data[{grant_id, 3'b000} +: 8];
            uart_tx_wr   <= 1'b1;
            last_q       <= req_bus.req_last[grant_id];
            cnt_q        <= '0;
            state_q      <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (uart_tx_busy) begin
            state_q <= StWaitDone;
          end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            ptr_q       <= grant_id;
            grant_valid <= 1'b0;
            state_q     <= StArb;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!uart_tx_busy) begin
            if ((LOCK_PACKETS != 0) && !last_q) begin
              state_q <= StSend;
            end else begin
              ptr_q       <= grant_id;
              grant_valid <= 1'b0;
              state_q     <= StArb;
            end
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule
